// File: rtl/perf_counters.sv
// Performance counters for cycles, retired instructions and I/D-cache requests/hits,
// frozen once HALT retires, with sticky saturation flags and a registered select-read port.
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regWrite,
    input  logic             memWrite,
    input  logic             halt,
    input  logic             iCacheReq,
    input  logic             iCacheHit,
    input  logic             dCacheReq,
    input  logic             dCacheHit,
    input  logic             clear,
    input  logic [2:0]       sel,
    output logic [CNT_W-1:0] cntOut,
    output logic             halted,
    output logic [5:0]       ovf
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt [6];
    logic [CNT_W-1:0] r_cnt_out;
    logic [5:0]       r_ovf;
    logic [5:0]       w_inc;
    logic [CNT_W-1:0] w_sel_val;

    // clear dominates; a halt seen while already halted has no effect
    always_comb begin
        w_next_state = r_state;
        if (clear) begin
            w_next_state = ST_RUN;
        end else if (r_state == ST_RUN && halt) begin
            w_next_state = ST_HALTED;
        end
    end

    always_comb begin
        w_inc = '0;
        if (r_state == ST_RUN) begin
            w_inc[0] = 1'b1;
            w_inc[1] = regWrite | memWrite | halt;
            w_inc[2] = iCacheReq;
            w_inc[3] = iCacheHit & iCacheReq;
            w_inc[4] = dCacheReq;
            w_inc[5] = dCacheHit & dCacheReq;
        end
    end

    always_comb begin
        w_sel_val = '0;
        case (sel)
            3'd0:    w_sel_val = r_cnt[0];
            3'd1:    w_sel_val = r_cnt[1];
            3'd2:    w_sel_val = r_cnt[2];
            3'd3:    w_sel_val = r_cnt[3];
            3'd4:    w_sel_val = r_cnt[4];
            3'd5:    w_sel_val = r_cnt[5];
            default: w_sel_val = '0;
        endcase
    end

    // The read port samples pre-update values, so it runs one edge behind the live counts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_RUN;
            r_cnt_out <= '0;
            r_ovf     <= '0;
            for (int i = 0; i < 6; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state   <= w_next_state;
            r_cnt_out <= w_sel_val;
            if (clear) begin
                r_ovf <= '0;
                for (int i = 0; i < 6; i++) begin
                    r_cnt[i] <= '0;
                end
            end else begin
                for (int i = 0; i < 6; i++) begin
                    if (w_inc[i]) begin
                        if (r_cnt[i] == CNT_MAX) begin
                            r_ovf[i] <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign cntOut = r_cnt_out;
    assign halted = (r_state == ST_HALTED);
    assign ovf    = r_ovf;

endmodule
